// File: rtl/au_arbiter.sv
// au_arbiter: two requesters share one 16-bit saturating add/sub/padd unit.
// Round-robin grant, registered operands, registered result with valid/ready
// return, and the architectural Z/V/N flag register fed by one requester.
module au_arbiter #(
    parameter logic RR_INIT  = 1'b0,
    parameter logic FLAG_REQ = 1'b0,
    localparam int unsigned DW = 16,
    localparam int unsigned CW = 4,
    localparam int unsigned LW = DW / 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [CW-1:0] req0_cmd,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [CW-1:0] req1_cmd,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          req1_ready,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_cout,
    input  logic          rsp_ready,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n,
    output logic          busy
);

    localparam int unsigned CMD_SUB  = 1;
    localparam int unsigned CMD_PADD = 3;

    localparam logic [DW-1:0] W_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] W_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [LW-1:0] L_MAX = {1'b0, {(LW-1){1'b1}}};
    localparam logic [LW-1:0] L_MIN = {1'b1, {(LW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          w_offer;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_grant;
    logic          w_gnt_id;
    logic          w_rsp_load;
    logic          w_rsp_take;

    logic          r_prio;
    logic          r_busy;

    logic          w_sel_sub;
    logic          w_sel_padd;
    logic [DW-1:0] w_sel_a;
    logic [DW-1:0] w_sel_b;

    logic          r_op_id;
    logic          r_op_sub;
    logic          r_op_padd;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;

    logic [DW-1:0] w_b_x;
    logic [DW:0]   w_sum;
    logic [LW:0]   w_lo;
    logic [LW:0]   w_hi;
    logic          w_ovf_w;
    logic          w_ovf_lo;
    logic          w_ovf_hi;
    logic [DW-1:0] w_res;
    logic          w_cout;
    logic          w_v;

    logic          r_rsp_valid;
    logic          r_rsp_id;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_cout;
    logic          r_flag_z;
    logic          r_flag_v;
    logic          r_flag_n;

    logic          w_unused;

    // Grant window and round-robin pick; window opens in IDLE or while the held result is consumed
    always_comb begin
        w_offer = 1'b0;
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_offer = rst_n && ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
        if (w_offer) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = ~r_prio;
                w_gnt1 = r_prio;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_grant    = w_gnt0 | w_gnt1;
    assign w_gnt_id   = w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Next-state and handshake strobes
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_load  = 1'b0;
        w_rsp_take  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_rsp_load  = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_take  = 1'b1;
                    w_state_nxt = w_grant ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; busy tracks the registered state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Mux the granted request; padd never subtracts
    always_comb begin
        w_sel_a    = w_gnt_id ? req1_a : req0_a;
        w_sel_b    = w_gnt_id ? req1_b : req0_b;
        w_sel_padd = w_gnt_id ? req1_cmd[CMD_PADD] : req0_cmd[CMD_PADD];
        w_sel_sub  = w_gnt_id ? req1_cmd[CMD_SUB] : req0_cmd[CMD_SUB];
        if (w_sel_padd) begin
            w_sel_sub = 1'b0;
        end
    end

    // Operand registers and priority pointer, loaded on the grant edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio    <= RR_INIT;
            r_op_id   <= 1'b0;
            r_op_sub  <= 1'b0;
            r_op_padd <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
        end else if (w_grant) begin
            r_prio    <= ~w_gnt_id;
            r_op_id   <= w_gnt_id;
            r_op_sub  <= w_sel_sub;
            r_op_padd <= w_sel_padd;
            r_op_a    <= w_sel_a;
            r_op_b    <= w_sel_b;
        end
    end

    // Saturating arithmetic unit on the operand registers
    always_comb begin
        w_b_x    = r_op_b ^ {DW{r_op_sub}};
        w_sum    = {1'b0, r_op_a} + {1'b0, w_b_x} + (DW+1)'(r_op_sub);
        w_ovf_w  = (r_op_a[DW-1] == w_b_x[DW-1]) && (w_sum[DW-1] != r_op_a[DW-1]);
        w_lo     = {1'b0, r_op_a[LW-1:0]} + {1'b0, r_op_b[LW-1:0]};
        w_hi     = {1'b0, r_op_a[DW-1:LW]} + {1'b0, r_op_b[DW-1:LW]};
        w_ovf_lo = (r_op_a[LW-1] == r_op_b[LW-1]) && (w_lo[LW-1] != r_op_a[LW-1]);
        w_ovf_hi = (r_op_a[DW-1] == r_op_b[DW-1]) && (w_hi[LW-1] != r_op_a[DW-1]);
        w_res    = w_sum[DW-1:0];
        w_cout   = w_sum[DW];
        w_v      = w_ovf_w;
        if (r_op_padd) begin
            // Two independent byte lanes, no carry from bit 7 into bit 8
            w_res[LW-1:0]  = w_ovf_lo ? (r_op_a[LW-1] ? L_MIN : L_MAX) : w_lo[LW-1:0];
            w_res[DW-1:LW] = w_ovf_hi ? (r_op_a[DW-1] ? L_MIN : L_MAX) : w_hi[LW-1:0];
            w_cout         = w_hi[LW];
            w_v            = w_ovf_lo | w_ovf_hi;
        end else if (w_ovf_w) begin
            // Clamp toward the sign of A: positive overflow to max, negative to min
            w_res = r_op_a[DW-1] ? W_MIN : W_MAX;
        end
    end

    // Response registers: load on EXEC exit, drop valid once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_cout  <= 1'b0;
        end else if (w_rsp_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_op_id;
            r_rsp_data  <= w_res;
            r_rsp_cout  <= w_cout;
        end else if (w_rsp_take) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Flag register, written only by the flag-owning requester's results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_rsp_load && (r_op_id == FLAG_REQ)) begin
            r_flag_z <= (w_res == '0);
            r_flag_v <= w_v;
            r_flag_n <= w_res[DW-1];
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_cout  = r_rsp_cout;
    assign flag_z    = r_flag_z;
    assign flag_v    = r_flag_v;
    assign flag_n    = r_flag_n;
    assign busy      = r_busy;

    // Command bits with no function here, and the low-lane carry which never leaves the unit
    assign w_unused = ^{w_lo[LW], req0_cmd[2], req0_cmd[0], req1_cmd[2], req1_cmd[0]};

endmodule
